// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master / two-slave AXI read arbiter.
// State enum, owner ID, response codes and AR field widths.
package axi_rd_arb_pkg;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  typedef logic owner_t;

  typedef enum logic [1:0] {
    TGT_S0,
    TGT_S1,
    TGT_NONE
  } tgt_t;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_ctl_t;

endpackage

// File: rtl/axi_rd_slave_port.sv
// Per-slave channel: IDLE/ADDR/DATA FSM, round-robin pointer, AR register.
// Grants are combinational in IDLE; the AR beat is issued from registers.
module axi_rd_slave_port
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [LEN_W-1:0]    m0_len,
  input  logic [SIZE_W-1:0]   m0_size,
  input  logic [BURST_W-1:0]  m0_burst,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [LEN_W-1:0]    m1_len,
  input  logic [SIZE_W-1:0]   m1_size,
  input  logic [BURST_W-1:0]  m1_burst,
  input  logic                s_arready,
  input  logic                r_done,
  output logic [1:0]          grant,
  output logic                owner,
  output logic                active,
  output logic                in_data,
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [LEN_W-1:0]    s_arlen,
  output logic [SIZE_W-1:0]   s_arsize,
  output logic [BURST_W-1:0]  s_arburst
);

  state_t      state;
  state_t      state_nx;
  logic        ptr;
  logic        pick;
  owner_t      own_q;
  logic [ADDR_W-1:0] addr_q;
  ar_ctl_t     ctl_q;

  // Winner selection: pointer breaks ties, a lone requester always wins
  always_comb begin
    pick = 1'b0;
    if (req[0] && req[1]) pick = ptr;
    else                  pick = req[1];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (|grant)    state_nx = ST_ADDR;
      ST_ADDR: if (s_arready) state_nx = ST_DATA;
      ST_DATA: if (r_done)    state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    grant     = 2'b00;
    s_arvalid = 1'b0;
    in_data   = 1'b0;
    unique case (state)
      ST_IDLE: if (|req && !rst) grant[pick] = 1'b1;
      ST_ADDR: s_arvalid = 1'b1;
      ST_DATA: in_data   = 1'b1;
      default: ;
    endcase
  end

  // Capture owner and AR fields on grant; pointer moves to the loser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= 1'b0;
      own_q  <= 1'b0;
      addr_q <= '0;
      ctl_q  <= '0;
    end else if (|grant) begin
      ptr    <= ~pick;
      own_q  <= pick;
      addr_q <= pick ? m1_addr : m0_addr;
      ctl_q  <= pick ? {m1_len, m1_size, m1_burst}
                     : {m0_len, m0_size, m0_burst};
    end
  end

  assign owner     = own_q;
  assign active    = (state != ST_IDLE);
  assign s_araddr  = addr_q;
  assign s_arlen   = ctl_q.len;
  assign s_arsize  = ctl_q.size;
  assign s_arburst = ctl_q.burst;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master / two-slave AXI read arbiter: decode, busy tracking, R routing.
// Define AXI_RD_ARB_DECERR_EN to answer unmapped reads with a DECERR beat.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              G_clk,
  input  logic              G_reset,
  input  logic [ADDR_W-1:0] M0_ARADDR,
  input  logic [3:0]        M0_ARLEN,
  input  logic [2:0]        M0_ARSIZE,
  input  logic [1:0]        M0_ARBURST,
  input  logic              M0_ARVALID,
  input  logic              M0_RREADY,
  input  logic [ADDR_W-1:0] M1_ARADDR,
  input  logic [3:0]        M1_ARLEN,
  input  logic [2:0]        M1_ARSIZE,
  input  logic [1:0]        M1_ARBURST,
  input  logic              M1_ARVALID,
  input  logic              M1_RREADY,
  output logic              ARREADY_M0,
  output logic              ARREADY_M1,
  output logic              RVALID_M0,
  output logic              RLAST_M0,
  output logic [1:0]        RRESP_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic              RVALID_M1,
  output logic              RLAST_M1,
  output logic [1:0]        RRESP_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [ADDR_W-1:0] ARADDR_S0,
  output logic [3:0]        ARLEN_S0,
  output logic [2:0]        ARSIZE_S0,
  output logic [1:0]        ARBURST_S0,
  output logic              ARVALID_S0,
  output logic              RREADY_S0,
  output logic [ADDR_W-1:0] ARADDR_S1,
  output logic [3:0]        ARLEN_S1,
  output logic [2:0]        ARSIZE_S1,
  output logic [1:0]        ARBURST_S1,
  output logic              ARVALID_S1,
  output logic              RREADY_S1,
  input  logic              S0_ARREADY,
  input  logic              S0_RVALID,
  input  logic              S0_RLAST,
  input  logic [1:0]        S0_RRESP,
  input  logic [DATA_W-1:0] S0_RDATA,
  input  logic              S1_ARREADY,
  input  logic              S1_RVALID,
  input  logic              S1_RLAST,
  input  logic [1:0]        S1_RRESP,
  input  logic [DATA_W-1:0] S1_RDATA,
  input  logic [ADDR_W-1:0] slave0_addr1,
  input  logic [ADDR_W-1:0] slave0_addr2,
  input  logic [ADDR_W-1:0] slave1_addr1,
  input  logic [ADDR_W-1:0] slave1_addr2
);

  tgt_t        tgt [2];
  logic [1:0]  busy;
  logic [1:0]  req0;
  logic [1:0]  req1;
  logic [1:0]  gnt0;
  logic [1:0]  gnt1;
  logic [1:0]  de_grant;
  logic [1:0]  de_pend;
  logic        own0;
  logic        own1;
  logic        act0;
  logic        act1;
  logic        dat0;
  logic        dat1;
  logic        done0;
  logic        done1;
  logic [ADDR_W-1:0] maddr [2];
  logic [1:0]  mvalid;
  logic [1:0]  mrready;

  assign maddr[0] = M0_ARADDR;
  assign maddr[1] = M1_ARADDR;
  assign mvalid   = {M1_ARVALID, M0_ARVALID};
  assign mrready  = {M1_RREADY, M0_RREADY};

  // Address decode; slave0 wins where the windows overlap
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      tgt[m] = TGT_NONE;
      priority case (1'b1)
        (maddr[m] >= slave0_addr1 && maddr[m] <= slave0_addr2):
          tgt[m] = TGT_S0;
        (maddr[m] >= slave1_addr1 && maddr[m] <= slave1_addr2):
          tgt[m] = TGT_S1;
        default: tgt[m] = TGT_NONE;
      endcase
    end
  end

  // A master is busy while any channel it owns has not retired
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      busy[m] = de_pend[m]
              | (act0 & (own0 == owner_t'(m)))
              | (act1 & (own1 == owner_t'(m)));
      req0[m] = mvalid[m] & ~busy[m] & (tgt[m] == TGT_S0);
      req1[m] = mvalid[m] & ~busy[m] & (tgt[m] == TGT_S1);
    end
  end

  axi_rd_slave_port #(.ADDR_W(ADDR_W)) u_port0 (
    .clk       (G_clk),
    .rst       (G_reset),
    .req       (req0),
    .m0_addr   (M0_ARADDR),
    .m0_len    (M0_ARLEN),
    .m0_size   (M0_ARSIZE),
    .m0_burst  (M0_ARBURST),
    .m1_addr   (M1_ARADDR),
    .m1_len    (M1_ARLEN),
    .m1_size   (M1_ARSIZE),
    .m1_burst  (M1_ARBURST),
    .s_arready (S0_ARREADY),
    .r_done    (done0),
    .grant     (gnt0),
    .owner     (own0),
    .active    (act0),
    .in_data   (dat0),
    .s_arvalid (ARVALID_S0),
    .s_araddr  (ARADDR_S0),
    .s_arlen   (ARLEN_S0),
    .s_arsize  (ARSIZE_S0),
    .s_arburst (ARBURST_S0)
  );

  axi_rd_slave_port #(.ADDR_W(ADDR_W)) u_port1 (
    .clk       (G_clk),
    .rst       (G_reset),
    .req       (req1),
    .m0_addr   (M0_ARADDR),
    .m0_len    (M0_ARLEN),
    .m0_size   (M0_ARSIZE),
    .m0_burst  (M0_ARBURST),
    .m1_addr   (M1_ARADDR),
    .m1_len    (M1_ARLEN),
    .m1_size   (M1_ARSIZE),
    .m1_burst  (M1_ARBURST),
    .s_arready (S1_ARREADY),
    .r_done    (done1),
    .grant     (gnt1),
    .owner     (own1),
    .active    (act1),
    .in_data   (dat1),
    .s_arvalid (ARVALID_S1),
    .s_araddr  (ARADDR_S1),
    .s_arlen   (ARLEN_S1),
    .s_arsize  (ARSIZE_S1),
    .s_arburst (ARBURST_S1)
  );

`ifdef AXI_RD_ARB_DECERR_EN
  // Unmapped requests from idle masters are accepted locally
  always_comb begin
    for (int m = 0; m < 2; m++)
      de_grant[m] = mvalid[m] & ~busy[m]
                  & (tgt[m] == TGT_NONE) & ~G_reset;
  end

  // Pending DECERR beat per master, retired on its RREADY
  always_ff @(posedge G_clk or posedge G_reset) begin
    if (G_reset) begin
      de_pend <= 2'b00;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (de_grant[m])                  de_pend[m] <= 1'b1;
        else if (de_pend[m] && mrready[m]) de_pend[m] <= 1'b0;
      end
    end
  end
`else
  assign de_grant = 2'b00;
  assign de_pend  = 2'b00;
`endif

  assign ARREADY_M0 = gnt0[0] | gnt1[0] | de_grant[0];
  assign ARREADY_M1 = gnt0[1] | gnt1[1] | de_grant[1];

  // Slave ready follows its owner; completion is the RLAST handshake
  always_comb begin
    RREADY_S0 = dat0 & (own0 ? M1_RREADY : M0_RREADY);
    RREADY_S1 = dat1 & (own1 ? M1_RREADY : M0_RREADY);
    done0     = RREADY_S0 & S0_RVALID & S0_RLAST;
    done1     = RREADY_S1 & S1_RVALID & S1_RLAST;
  end

  // Route R beats to the owning master, zero otherwise
  always_comb begin
    RVALID_M0 = 1'b0;
    RLAST_M0  = 1'b0;
    RRESP_M0  = RESP_OKAY;
    RDATA_M0  = '0;
    RVALID_M1 = 1'b0;
    RLAST_M1  = 1'b0;
    RRESP_M1  = RESP_OKAY;
    RDATA_M1  = '0;
    if (de_pend[0]) begin
      RVALID_M0 = 1'b1;
      RLAST_M0  = 1'b1;
      RRESP_M0  = RESP_DECERR;
    end else if (dat0 && !own0) begin
      RVALID_M0 = S0_RVALID;
      RLAST_M0  = S0_RLAST;
      RRESP_M0  = S0_RRESP;
      RDATA_M0  = S0_RDATA;
    end else if (dat1 && !own1) begin
      RVALID_M0 = S1_RVALID;
      RLAST_M0  = S1_RLAST;
      RRESP_M0  = S1_RRESP;
      RDATA_M0  = S1_RDATA;
    end
    if (de_pend[1]) begin
      RVALID_M1 = 1'b1;
      RLAST_M1  = 1'b1;
      RRESP_M1  = RESP_DECERR;
    end else if (dat0 && own0) begin
      RVALID_M1 = S0_RVALID;
      RLAST_M1  = S0_RLAST;
      RRESP_M1  = S0_RRESP;
      RDATA_M1  = S0_RDATA;
    end else if (dat1 && own1) begin
      RVALID_M1 = S1_RVALID;
      RLAST_M1  = S1_RLAST;
      RRESP_M1  = S1_RRESP;
      RDATA_M1  = S1_RDATA;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter.
// Map: slave0 = 0..5, slave1 = 8..15, 6..7 and above 15 unmapped.
module tb_axi_rd_arbiter;

  logic        G_clk = 1'b0;
  logic        G_reset;
  logic [31:0] M0_ARADDR, M1_ARADDR;
  logic [3:0]  M0_ARLEN, M1_ARLEN;
  logic [2:0]  M0_ARSIZE, M1_ARSIZE;
  logic [1:0]  M0_ARBURST, M1_ARBURST;
  logic        M0_ARVALID, M1_ARVALID, M0_RREADY, M1_RREADY;
  logic        ARREADY_M0, ARREADY_M1;
  logic        RVALID_M0, RLAST_M0, RVALID_M1, RLAST_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [31:0] ARADDR_S0, ARADDR_S1;
  logic [3:0]  ARLEN_S0, ARLEN_S1;
  logic [2:0]  ARSIZE_S0, ARSIZE_S1;
  logic [1:0]  ARBURST_S0, ARBURST_S1;
  logic        ARVALID_S0, ARVALID_S1, RREADY_S0, RREADY_S1;
  logic        S0_ARREADY, S0_RVALID, S0_RLAST;
  logic        S1_ARREADY, S1_RVALID, S1_RLAST;
  logic [1:0]  S0_RRESP, S1_RRESP;
  logic [31:0] S0_RDATA, S1_RDATA;
  logic [31:0] slave0_addr1, slave0_addr2, slave1_addr1, slave1_addr2;

  int total = 0;
  int bad   = 0;

  always #5 G_clk = ~G_clk;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .G_clk(G_clk), .G_reset(G_reset),
    .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
    .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_RREADY(M0_RREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
    .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_RREADY(M1_RREADY),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
    .RVALID_M0(RVALID_M0), .RLAST_M0(RLAST_M0), .RRESP_M0(RRESP_M0),
    .RDATA_M0(RDATA_M0),
    .RVALID_M1(RVALID_M1), .RLAST_M1(RLAST_M1), .RRESP_M1(RRESP_M1),
    .RDATA_M1(RDATA_M1),
    .ARADDR_S0(ARADDR_S0), .ARLEN_S0(ARLEN_S0), .ARSIZE_S0(ARSIZE_S0),
    .ARBURST_S0(ARBURST_S0), .ARVALID_S0(ARVALID_S0), .RREADY_S0(RREADY_S0),
    .ARADDR_S1(ARADDR_S1), .ARLEN_S1(ARLEN_S1), .ARSIZE_S1(ARSIZE_S1),
    .ARBURST_S1(ARBURST_S1), .ARVALID_S1(ARVALID_S1), .RREADY_S1(RREADY_S1),
    .S0_ARREADY(S0_ARREADY), .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST),
    .S0_RRESP(S0_RRESP), .S0_RDATA(S0_RDATA),
    .S1_ARREADY(S1_ARREADY), .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST),
    .S1_RRESP(S1_RRESP), .S1_RDATA(S1_RDATA),
    .slave0_addr1(slave0_addr1), .slave0_addr2(slave0_addr2),
    .slave1_addr1(slave1_addr1), .slave1_addr2(slave1_addr2)
  );

  task automatic tick();
    @(posedge G_clk);
    #1;
  endtask

  task automatic idle_inputs();
    M0_ARVALID = 0; M1_ARVALID = 0; M0_RREADY = 0; M1_RREADY = 0;
    M0_ARADDR = 0; M1_ARADDR = 0;
    M0_ARLEN = 0; M1_ARLEN = 0; M0_ARSIZE = 3'd2; M1_ARSIZE = 3'd2;
    M0_ARBURST = 2'd1; M1_ARBURST = 2'd1;
    S0_ARREADY = 0; S0_RVALID = 0; S0_RLAST = 0; S0_RRESP = 0; S0_RDATA = 0;
    S1_ARREADY = 0; S1_RVALID = 0; S1_RLAST = 0; S1_RRESP = 0; S1_RDATA = 0;
  endtask

  task automatic do_reset();
    G_reset = 1;
    tick();
    tick();
    G_reset = 0;
    tick();
  endtask

  task automatic test_reset();
    G_reset = 1;
    M0_ARVALID = 1; M0_ARADDR = 3;
    tick();
    #1;
    total++;
    if (ARREADY_M0 !== 1'b0) begin
      bad++; $display("FAIL rst_arready got=%0b exp=0", ARREADY_M0);
    end
    total++;
    if (ARVALID_S0 !== 1'b0 || ARVALID_S1 !== 1'b0) begin
      bad++; $display("FAIL rst_arvalid got=%0b%0b exp=00", ARVALID_S0, ARVALID_S1);
    end
    total++;
    if (ARADDR_S0 !== 32'd0 || RVALID_M0 !== 1'b0) begin
      bad++; $display("FAIL rst_state addr=%0d rv=%0b exp=0/0", ARADDR_S0, RVALID_M0);
    end
    idle_inputs();
    G_reset = 0;
    tick();
  endtask

  task automatic test_basic();
    M0_ARVALID = 1; M0_ARADDR = 12; M0_ARLEN = 1;
    #1;
    total++;
    if (ARREADY_M0 !== 1'b1 || ARREADY_M1 !== 1'b0) begin
      bad++; $display("FAIL bas_grant got=%0b%0b exp=10", ARREADY_M0, ARREADY_M1);
    end
    tick();
    M0_ARVALID = 0;
    #1;
    total++;
    if (ARVALID_S1 !== 1'b1 || ARADDR_S1 !== 32'd12 || ARLEN_S1 !== 4'd1) begin
      bad++; $display("FAIL bas_ar got v=%0b a=%0d l=%0d exp 1/12/1", ARVALID_S1, ARADDR_S1, ARLEN_S1);
    end
    total++;
    if (ARREADY_M0 !== 1'b0 || ARVALID_S0 !== 1'b0) begin
      bad++; $display("FAIL bas_pulse got=%0b s0=%0b exp=0/0", ARREADY_M0, ARVALID_S0);
    end
    S1_ARREADY = 1;
    tick();
    S1_ARREADY = 0;
    S1_RVALID = 1; S1_RLAST = 1; S1_RDATA = 1;
    #1;
    total++;
    if (RVALID_M0 !== 1'b1 || RDATA_M0 !== 32'd1 || RLAST_M0 !== 1'b1) begin
      bad++; $display("FAIL bas_r got v=%0b d=%0d l=%0b exp 1/1/1", RVALID_M0, RDATA_M0, RLAST_M0);
    end
    total++;
    if (RREADY_S1 !== 1'b0 || RVALID_M1 !== 1'b0 || ARVALID_S1 !== 1'b0) begin
      bad++; $display("FAIL bas_rdy0 got rr=%0b v1=%0b av=%0b exp 0/0/0", RREADY_S1, RVALID_M1, ARVALID_S1);
    end
    M0_RREADY = 1;
    #1;
    total++;
    if (RREADY_S1 !== 1'b1) begin
      bad++; $display("FAIL bas_rdy1 got=%0b exp=1", RREADY_S1);
    end
    tick();
    #1;
    total++;
    if (RVALID_M0 !== 1'b0 || RREADY_S1 !== 1'b0) begin
      bad++; $display("FAIL bas_idle got v=%0b rr=%0b exp 0/0", RVALID_M0, RREADY_S1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    M0_ARVALID = 1; M0_ARADDR = 3;
    M1_ARVALID = 1; M1_ARADDR = 4;
    #1;
    total++;
    if (ARREADY_M0 !== 1'b1 || ARREADY_M1 !== 1'b0) begin
      bad++; $display("FAIL rr_first got=%0b%0b exp=10", ARREADY_M0, ARREADY_M1);
    end
    tick();
    M0_ARVALID = 0;
    #1;
    total++;
    if (ARADDR_S0 !== 32'd3 || ARVALID_S0 !== 1'b1 || ARREADY_M1 !== 1'b0) begin
      bad++; $display("FAIL rr_ar0 got a=%0d v=%0b g1=%0b exp 3/1/0", ARADDR_S0, ARVALID_S0, ARREADY_M1);
    end
    S0_ARREADY = 1;
    tick();
    S0_ARREADY = 0;
    S0_RVALID = 1; S0_RLAST = 1; S0_RDATA = 5; M0_RREADY = 1;
    M0_ARVALID = 1; M0_ARADDR = 3;
    #1;
    total++;
    if (RDATA_M0 !== 32'd5 || ARREADY_M1 !== 1'b0 || ARREADY_M0 !== 1'b0) begin
      bad++; $display("FAIL rr_last got d=%0d g=%0b%0b exp 5/00", RDATA_M0, ARREADY_M0, ARREADY_M1);
    end
    tick();
    S0_RVALID = 0; S0_RLAST = 0; M0_RREADY = 0;
    #1;
    total++;
    if (ARREADY_M1 !== 1'b1 || ARREADY_M0 !== 1'b0) begin
      bad++; $display("FAIL rr_second got=%0b%0b exp=01", ARREADY_M0, ARREADY_M1);
    end
    tick();
    M0_ARVALID = 0; M1_ARVALID = 0;
    #1;
    total++;
    if (ARADDR_S0 !== 32'd4 || ARVALID_S0 !== 1'b1) begin
      bad++; $display("FAIL rr_ar1 got a=%0d v=%0b exp 4/1", ARADDR_S0, ARVALID_S0);
    end
    S0_ARREADY = 1;
    tick();
    S0_ARREADY = 0;
    S0_RVALID = 1; S0_RLAST = 1; S0_RDATA = 9; M1_RREADY = 1;
    #1;
    total++;
    if (RVALID_M1 !== 1'b1 || RDATA_M1 !== 32'd9 || RVALID_M0 !== 1'b0) begin
      bad++; $display("FAIL rr_r1 got v1=%0b d=%0d v0=%0b exp 1/9/0", RVALID_M1, RDATA_M1, RVALID_M0);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_concurrent();
    M0_ARVALID = 1; M0_ARADDR = 12;
    M1_ARVALID = 1; M1_ARADDR = 3;
    #1;
    total++;
    if (ARREADY_M0 !== 1'b1 || ARREADY_M1 !== 1'b1) begin
      bad++; $display("FAIL cc_grant got=%0b%0b exp=11", ARREADY_M0, ARREADY_M1);
    end
    tick();
    M0_ARVALID = 0; M1_ARVALID = 0;
    #1;
    total++;
    if (ARVALID_S0 !== 1'b1 || ARVALID_S1 !== 1'b1 || ARADDR_S0 !== 32'd3 || ARADDR_S1 !== 32'd12) begin
      bad++; $display("FAIL cc_ar got %0b%0b a0=%0d a1=%0d exp 11/3/12", ARVALID_S0, ARVALID_S1, ARADDR_S0, ARADDR_S1);
    end
    S0_ARREADY = 1; S1_ARREADY = 1;
    tick();
    S0_ARREADY = 0; S1_ARREADY = 0;
    S1_RVALID = 1; S1_RLAST = 1; S1_RDATA = 2;
    S0_RVALID = 1; S0_RLAST = 1; S0_RDATA = 11;
    M0_RREADY = 1; M1_RREADY = 1;
    #1;
    total++;
    if (RDATA_M0 !== 32'd2 || RDATA_M1 !== 32'd11 || RVALID_M0 !== 1'b1 || RVALID_M1 !== 1'b1) begin
      bad++; $display("FAIL cc_r got d0=%0d d1=%0d exp 2/11", RDATA_M0, RDATA_M1);
    end
    total++;
    if (RREADY_S0 !== 1'b1 || RREADY_S1 !== 1'b1) begin
      bad++; $display("FAIL cc_rready got=%0b%0b exp=11", RREADY_S0, RREADY_S1);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_unmapped();
    int hits;
    hits = 0;
    M1_ARVALID = 1; M1_ARADDR = 7;
`ifdef AXI_RD_ARB_DECERR_EN
    #1;
    total++;
    if (ARREADY_M1 !== 1'b1) begin
      bad++; $display("FAIL de_accept got=%0b exp=1", ARREADY_M1);
    end
    tick();
    M1_ARVALID = 0;
    #1;
    total++;
    if (RVALID_M1 !== 1'b1 || RLAST_M1 !== 1'b1 || RRESP_M1 !== 2'b11 || RDATA_M1 !== 32'd0) begin
      bad++; $display("FAIL de_beat got v=%0b l=%0b r=%0d d=%0d exp 1/1/3/0", RVALID_M1, RLAST_M1, RRESP_M1, RDATA_M1);
    end
    tick();
    #1;
    total++;
    if (RVALID_M1 !== 1'b1 || RRESP_M1 !== 2'b11 || RLAST_M1 !== 1'b1) begin
      bad++; $display("FAIL de_hold got v=%0b r=%0d exp 1/3", RVALID_M1, RRESP_M1);
    end
    M1_RREADY = 1;
    tick();
    M1_RREADY = 0;
    #1;
    total++;
    if (RVALID_M1 !== 1'b0) begin
      bad++; $display("FAIL de_retire got=%0b exp=0", RVALID_M1);
    end
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ARREADY_M1 !== 1'b0 || ARVALID_S0 !== 1'b0 || ARVALID_S1 !== 1'b0) hits++;
      tick();
    end
    total++;
    if (hits != 0) begin
      bad++; $display("FAIL un_reject got=%0d cycles exp=0", hits);
    end
    total++;
    if (RVALID_M1 !== 1'b0) begin
      bad++; $display("FAIL un_norvalid got=%0b exp=0", RVALID_M1);
    end
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    M0_ARVALID = 1; M0_ARADDR = 12;
    tick();
    M0_ARVALID = 0;
    S1_ARREADY = 1;
    tick();
    S1_ARREADY = 0;
    S1_RVALID = 1; S1_RLAST = 0; S1_RDATA = 33; M0_RREADY = 1;
    #1;
    total++;
    if (RVALID_M0 !== 1'b1 || RREADY_S1 !== 1'b1) begin
      bad++; $display("FAIL rm_pre got v=%0b rr=%0b exp 1/1", RVALID_M0, RREADY_S1);
    end
    #1;
    G_reset = 1;
    #1;
    total++;
    if (RVALID_M0 !== 1'b0 || RREADY_S1 !== 1'b0 || ARVALID_S1 !== 1'b0 || RDATA_M0 !== 32'd0) begin
      bad++; $display("FAIL rm_async got v=%0b rr=%0b av=%0b d=%0d exp 0/0/0/0", RVALID_M0, RREADY_S1, ARVALID_S1, RDATA_M0);
    end
    tick();
    G_reset = 0;
    S1_RLAST = 1;
    #1;
    total++;
    if (RVALID_M0 !== 1'b0 || RREADY_S1 !== 1'b0) begin
      bad++; $display("FAIL rm_stale got v=%0b rr=%0b exp 0/0", RVALID_M0, RREADY_S1);
    end
    tick();
    S1_RVALID = 0; S1_RLAST = 0; M0_RREADY = 0;
    M1_ARVALID = 1; M1_ARADDR = 10;
    #1;
    total++;
    if (ARREADY_M1 !== 1'b1) begin
      bad++; $display("FAIL rm_regrant got=%0b exp=1", ARREADY_M1);
    end
    tick();
    M1_ARVALID = 0;
    #1;
    total++;
    if (ARVALID_S1 !== 1'b1 || ARADDR_S1 !== 32'd10) begin
      bad++; $display("FAIL rm_ar got v=%0b a=%0d exp 1/10", ARVALID_S1, ARADDR_S1);
    end
    S1_ARREADY = 1;
    tick();
    S1_ARREADY = 0;
    S1_RVALID = 1; S1_RLAST = 1; M1_RREADY = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_busy();
    M0_ARVALID = 1; M0_ARADDR = 12;
    tick();
    M0_ARADDR = 2;
    S1_ARREADY = 1;
    #1;
    total++;
    if (ARREADY_M0 !== 1'b0) begin
      bad++; $display("FAIL bz_addr got=%0b exp=0", ARREADY_M0);
    end
    tick();
    S1_ARREADY = 0;
    tick();
    #1;
    total++;
    if (ARREADY_M0 !== 1'b0 || ARVALID_S0 !== 1'b0) begin
      bad++; $display("FAIL bz_data got=%0b s0=%0b exp=0/0", ARREADY_M0, ARVALID_S0);
    end
    S1_RVALID = 1; S1_RLAST = 1; M0_RREADY = 1;
    #1;
    total++;
    if (ARREADY_M0 !== 1'b0) begin
      bad++; $display("FAIL bz_last got=%0b exp=0", ARREADY_M0);
    end
    tick();
    S1_RVALID = 0; S1_RLAST = 0; M0_RREADY = 0;
    #1;
    total++;
    if (ARREADY_M0 !== 1'b1) begin
      bad++; $display("FAIL bz_grant got=%0b exp=1", ARREADY_M0);
    end
    tick();
    M0_ARVALID = 0;
    #1;
    total++;
    if (ARVALID_S0 !== 1'b1 || ARADDR_S0 !== 32'd2) begin
      bad++; $display("FAIL bz_ar got v=%0b a=%0d exp 1/2", ARVALID_S0, ARADDR_S0);
    end
    S0_ARREADY = 1;
    tick();
    S0_ARREADY = 0;
    S0_RVALID = 1; S0_RLAST = 1; M0_RREADY = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    slave0_addr1 = 0;  slave0_addr2 = 5;
    slave1_addr1 = 8;  slave1_addr2 = 15;
    idle_inputs();
    G_reset = 1;
    tick();
    test_reset();
    test_basic();
    test_round_robin();
    test_concurrent();
    test_unmapped();
    test_reset_mid();
    test_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
